// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-serial program loader.
// Optional checksum support is enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StChk,
        StDone,
        StErr
    } state_e;

    localparam int unsigned WORD_BYTES = 2;
    localparam int unsigned COUNT_W    = 9;
    // A header of 0 requests a full 256-word program.
    localparam logic [COUNT_W-1:0] FULL_COUNT = 9'd256;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser for the asynchronous byte strobe, followed by a
// rising-edge detector that emits a single-cycle accept pulse.
module strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic accept
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= strobe;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign accept = s2_q & ~s3_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-serial program loader: header N, then N words hi byte first, written to
// instruction memory from address 0. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [7:0]        byte_in,
    input  logic              byte_strobe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned BYTE_W = DATA_W / WORD_BYTES;

    state_e               state_q, state_d;
    logic                 load_en_q;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [COUNT_W-1:0]   remaining_q, remaining_d;
    logic [BYTE_W-1:0]    hi_q, hi_d;
    logic                 we_d;
    logic [ADDR_W-1:0]    waddr_d;
    logic [DATA_W-1:0]    wdata_d;
    logic                 hold_d, done_d, err_d;
    logic                 accept;
    logic                 load_rise;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]           xor_q, xor_d;
`endif

    strobe_sync u_strobe_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (byte_strobe),
        .accept (accept)
    );

    assign load_rise = load_en & ~load_en_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            load_en_q   <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            hi_q        <= '0;
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            cpu_hold    <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            load_en_q   <= load_en;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            hi_q        <= hi_d;
            mem_we      <= we_d;
            mem_waddr   <= waddr_d;
            mem_wdata   <= wdata_d;
            cpu_hold    <= hold_d;
            load_done   <= done_d;
            load_err    <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        hi_d        = hi_q;
        we_d        = 1'b0;
        waddr_d     = mem_waddr;
        wdata_d     = mem_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        unique case (state_q)
            StIdle, StDone, StErr: begin
                // Strobes are ignored here; only a fresh load_en edge starts a session.
                if (load_rise) begin
                    state_d = StCount;
                    addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            StCount: begin
                if (!load_en) begin
                    state_d = StErr;
                end else if (accept) begin
                    remaining_d = (byte_in == 8'd0) ? FULL_COUNT : {1'b0, byte_in};
                    state_d     = StHi;
                end
            end
            StHi: begin
                if (!load_en) begin
                    state_d = StErr;
                end else if (accept) begin
                    hi_d    = byte_in;
                    state_d = StLo;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ byte_in;
`endif
                end
            end
            StLo: begin
                // Abort takes priority over a coincident byte: no write.
                if (!load_en) begin
                    state_d = StErr;
                end else if (accept) begin
                    we_d        = 1'b1;
                    waddr_d     = addr_q;
                    wdata_d     = {hi_q, byte_in};
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - COUNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d       = xor_q ^ byte_in;
                    state_d     = (remaining_q == COUNT_W'(1)) ? StChk : StHi;
`else
                    state_d     = (remaining_q == COUNT_W'(1)) ? StDone : StHi;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            StChk: begin
                if (!load_en) begin
                    state_d = StErr;
                end else if (accept) begin
                    state_d = (byte_in == xor_q) ? StDone : StErr;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Flags are registered from the next state so they line up with the final write.
    always_comb begin
        hold_d = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        unique case (state_d)
            StCount, StHi, StLo, StChk: hold_d = 1'b1;
            StErr: begin
                hold_d = 1'b1;
                err_d  = 1'b1;
            end
            StDone:  done_d = 1'b1;
            default: hold_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [7:0]  byte_in;
    logic        byte_strobe;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int unsigned total = 0;
    int unsigned bad = 0;

    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int unsigned adjacent = 0;
    int unsigned accepts = 0;
    logic        prev_we = 1'b0;
    logic        done_at_we = 1'b0;

    prog_loader #(
        .ADDR_W (8),
        .DATA_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .byte_in     (byte_in),
        .byte_strobe (byte_strobe),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            if (prev_we) adjacent++;
            wr_addr.push_back(mem_waddr);
            wr_data.push_back(mem_wdata);
            done_at_we = load_done;
        end
        prev_we = mem_we;
        if (dut.accept) accepts++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi_cyc = 3, input int lo_cyc = 3);
        byte_in     = b;
        byte_strobe = 1'b1;
        tick(hi_cyc);
        byte_strobe = 1'b0;
        tick(lo_cyc);
    endtask

    task automatic start_load();
        load_en = 1'b0;
        tick(2);
        load_en = 1'b1;
        tick(2);
        wr_addr.delete();
        wr_data.delete();
        adjacent = 0;
        accepts  = 0;
    endtask

    initial begin
        logic [7:0] hi_b, lo_b;
        rst_n       = 1'b0;
        load_en     = 1'b0;
        byte_in     = 8'h00;
        byte_strobe = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_waddr", mem_waddr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_hold", cpu_hold, 0);
        check_eq("rst_done", load_done, 0);
        check_eq("rst_err", load_err, 0);
        check_eq("rst_state", dut.state_q, StIdle);

        send_byte(8'h55);
        check_eq("idle_strobe_writes", wr_addr.size(), 0);
        check_eq("idle_strobe_state", dut.state_q, StIdle);

        // Basic two-word load
        start_load();
        check_eq("count_hold", cpu_hold, 1);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        check_eq("mid_hold", cpu_hold, 1);
        send_byte(8'hCD);
`ifdef PROG_LOADER_CHECKSUM_EN
        check_eq("final_we_done", done_at_we, 0);
        check_eq("chk_wait_hold", cpu_hold, 1);
        send_byte(8'h40);
`else
        check_eq("final_we_done", done_at_we, 1);
`endif
        check_eq("basic_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check_eq("basic_a0", wr_addr[0], 8'h00);
            check_eq("basic_d0", wr_data[0], 16'h1234);
            check_eq("basic_a1", wr_addr[1], 8'h01);
            check_eq("basic_d1", wr_data[1], 16'hABCD);
        end
        check_eq("basic_done", load_done, 1);
        check_eq("basic_hold", cpu_hold, 0);
        check_eq("basic_err", load_err, 0);
        send_byte(8'h77);
        check_eq("done_strobe_ignored", wr_addr.size(), 2);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad check byte, then a clean reload
        start_load();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h41);
        check_eq("badchk_err", load_err, 1);
        check_eq("badchk_hold", cpu_hold, 1);
        check_eq("badchk_done", load_done, 0);
        start_load();
        check_eq("reload_state", dut.state_q, StCount);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h40);
        check_eq("reload_done", load_done, 1);
        check_eq("reload_nwr", wr_addr.size(), 2);
`endif

        // Full 256-word load via header 0
        start_load();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            hi_b = 8'(i);
            lo_b = 8'(i) ^ 8'hA5;
            send_byte(hi_b);
            send_byte(lo_b);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check_eq("full_nwr", wr_addr.size(), 256);
        if (wr_addr.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                hi_b = 8'(i);
                lo_b = 8'(i) ^ 8'hA5;
                check_eq($sformatf("full_a%0d", i), wr_addr[i], hi_b);
                check_eq($sformatf("full_d%0d", i), wr_data[i], {hi_b, lo_b});
            end
        end
        check_eq("full_addr_wrap", dut.addr_q, 0);
        check_eq("full_done", load_done, 1);
        send_byte(8'h99);
        send_byte(8'h98);
        check_eq("full_no_extra", wr_addr.size(), 256);

        // Abort after hi byte of word 1
        start_load();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        load_en = 1'b0;
        tick(1);
        check_eq("abort_err", load_err, 1);
        check_eq("abort_hold", cpu_hold, 1);
        check_eq("abort_done", load_done, 0);
        tick(2);
        check_eq("abort_nwr", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check_eq("abort_a0", wr_addr[0], 8'h00);
            check_eq("abort_d0", wr_data[0], 16'h1122);
        end

        // Minimum-width strobe pulses: 2 high, 2 low
        start_load();
        send_byte(8'h04, 2, 2);
        for (int i = 1; i <= 8; i++) begin
            lo_b = 8'(i);
            send_byte(lo_b, 2, 2);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h08, 2, 2);
        check_eq("fast_accepts", accepts, 10);
`else
        check_eq("fast_accepts", accepts, 9);
`endif
        tick(3);
        check_eq("fast_nwr", wr_addr.size(), 4);
        check_eq("fast_adjacent", adjacent, 0);
        if (wr_data.size() == 4) begin
            check_eq("fast_d0", wr_data[0], 16'h0102);
            check_eq("fast_d3", wr_data[3], 16'h0708);
            check_eq("fast_a3", wr_addr[3], 8'h03);
        end
        check_eq("fast_done", load_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-serial program loader that sits directly upstream of the instruction memory and the CPU core in the tt_um_bitty top. It receives a program over the 8-bit dedicated input pins with an asynchronous strobe, assembles 16-bit instructions high byte first, and writes them into instruction memory starting at address 0. While it loads, it holds the CPU and PC in reset; on a clean load it releases them.

## Interface
Parameters:
- ADDR_W, 8, instruction memory address width; one word per address.
- DATA_W, 16, instruction width; always two bytes.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- load_en  in  1  level; its rising edge starts a load session.
- byte_in  in  8  data byte; stable from strobe rise until strobe fall.
- byte_strobe  in  1  asynchronous byte strobe from a pin; the rising edge marks a byte.
- mem_we  out  1  one-cycle instruction memory write enable.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data, {hi, lo}.
- cpu_hold  out  1  holds the PC and CPU in reset while high.
- load_done  out  1  high while in DONE.
- load_err  out  1  high while in ERR.

## Operation
- Protocol: header byte N (words to load; 0 means 256), then 2·N bytes, hi byte then lo byte per word. With checksum enabled, one trailing check byte follows.
- States: IDLE, COUNT, HI, LO, CHK, DONE, ERR.
- IDLE / DONE / ERR → COUNT on load_en rising edge (load_en=1, load_en_q=0); this clears the address counter and checksum.
- COUNT: an accepted byte loads remaining = (byte==0) ? 256 : byte (9-bit) → HI.
- HI: an accepted byte is latched as hi → LO.
- LO: an accepted byte triggers a write of {hi, byte} at addr; addr increments (8-bit, wraps 255→0); remaining decrements. If remaining becomes 0: → CHK when the checksum is enabled, otherwise → DONE. Else → HI.
- CHK: an accepted byte equal to the running XOR → DONE, otherwise → ERR.
- load_en low in COUNT/HI/LO/CHK → ERR next cycle (abort). Already-written words remain in memory.
- cpu_hold = 1 in COUNT, HI, LO, CHK, ERR; 0 in IDLE and DONE.
- A strobe accepted in IDLE, DONE or ERR is ignored.
- Reset: state IDLE, addr 0, mem_we 0, mem_waddr 0, mem_wdata 0, cpu_hold 0, load_done 0, load_err 0, load_en_q 0, sync flops 0.

## Timing
- Strobe synchroniser: two flops, then an edge-detect flop. A byte is accepted in the cycle where s2=1 and s3=0, and byte_in is sampled in that cycle. Acceptance occurs 2–3 clk after the strobe rises at the pin.
- At most one byte is accepted per strobe rise. The strobe must be high ≥2 clk and low ≥2 clk.
- mem_we, mem_waddr and mem_wdata are registered: they are valid for exactly one cycle, the cycle after the lo byte is accepted.
- State and flag outputs are registered. DONE/ERR is visible the cycle after the deciding byte is accepted, so the final mem_we and load_done rise together.
- Simultaneous load_en fall and byte acceptance in a loading state: the abort wins, → ERR, and no write occurs.
- A load_en rising edge in a loading state is impossible, because load_en is already high.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined:
  - CHK state is compiled in.
  - The running XOR covers all 2·N data bytes; the header is excluded.
  - A mismatch → ERR.
- Not defined:
  - CHK and the XOR register are absent.
  - The final lo byte → DONE.
  - load_err is asserted only by an abort.

## Structure
- prog_loader_pkg: state enum (3-bit), WORD_BYTES=2, the N==0 → 256 constant.
- Sub-module strobe_sync: 2-flop synchroniser plus rising-edge pulse. It has its own clk/rst_n and outputs a one-cycle `accept` pulse.

## Test plan
- Reset with rst_n=0 for 2 cycles → all outputs 0, state IDLE; a strobe while IDLE produces no mem_we.
- load_en 0→1, then bytes 02,12,34,AB,CD (plus check byte 12^34^AB^CD=40 when enabled) → writes (0,1234), (1,ABCD); cpu_hold high during the load, then load_done=1 and cpu_hold=0.
- Checksum enabled, same program with check byte 41 → load_err=1, cpu_hold stays 1; a new load_en rising edge → COUNT, and a correct reload → DONE.
- Header 00 followed by 512 bytes → 256 writes at addresses 0..255 and back to 0, with no write past the 256th.
- load_en dropped after the hi byte of word 1 → ERR next cycle, only word 0 written, cpu_hold=1.
- Strobe pulse high for 2 clk and low for 2 clk repeatedly → exactly one acceptance per pulse; mem_we pulses are never adjacent.
